// File: rtl/data_checker.sv
// rtl/data_checker.sv - receive-side checker for fixed-length numbered AXI stream packets
// Counts good and errored packets, keeps sticky error flags and captures the first error.
module data_checker #(
  parameter int ZERO_LEN_SUB = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   packet_length,
  input  logic [63:0]  packet_count,
  input  logic         start,
  input  logic [511:0] AXIS_RX_TDATA,
  input  logic [63:0]  AXIS_RX_TKEEP,
  input  logic         AXIS_RX_TVALID,
  input  logic         AXIS_RX_TLAST,
  output logic         AXIS_RX_TREADY,
  output logic [63:0]  packets_rcvd,
  output logic [31:0]  error_count,
  output logic [3:0]   err_flags,
  output logic [63:0]  first_err_pkt,
  output logic [7:0]   first_err_beat,
  output logic         complete
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [7:0]  len_q, len_d;
  logic [63:0] cnt_q, cnt_d;
  logic [63:0] exp_pkt_q, exp_pkt_d;
  logic [7:0]  beat_idx_q, beat_idx_d;
  logic        pkt_err_q, pkt_err_d;
  logic        long_seen_q, long_seen_d;
  logic [63:0] packets_rcvd_q, packets_rcvd_d;
  logic [31:0] error_count_q, error_count_d;
  logic [3:0]  err_flags_q, err_flags_d;
  logic [63:0] first_err_pkt_q, first_err_pkt_d;
  logic [7:0]  first_err_beat_q, first_err_beat_d;
  logic        first_err_vld_q, first_err_vld_d;

  logic       between, apply, tready, accept;
  logic       data_err, keep_err, short_err, long_err, any_err;

  always_comb begin
    state_d          = state_q;
    pend_d           = pend_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    exp_pkt_d        = exp_pkt_q;
    beat_idx_d       = beat_idx_q;
    pkt_err_d        = pkt_err_q;
    long_seen_d      = long_seen_q;
    packets_rcvd_d   = packets_rcvd_q;
    error_count_d    = error_count_q;
    err_flags_d      = err_flags_q;
    first_err_pkt_d  = first_err_pkt_q;
    first_err_beat_d = first_err_beat_q;
    first_err_vld_d  = first_err_vld_q;

    between = (state_q == IDLE) || (beat_idx_q == 8'd1);
    apply   = pend_q && between;
    tready  = (state_q == RUN) && !apply;
    accept  = AXIS_RX_TVALID && tready;

    data_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (AXIS_RX_TDATA[64*i +: 64] != exp_pkt_q) data_err = 1'b1;
    end
    keep_err  = (AXIS_RX_TKEEP != '1);
    short_err = AXIS_RX_TLAST && (beat_idx_q < len_q);
    long_err  = !AXIS_RX_TLAST && (beat_idx_q == len_q) && !long_seen_q;
    any_err   = data_err || keep_err || short_err || long_err;

    if (apply) begin
      pend_d           = 1'b0;
      state_d          = RUN;
      len_d            = (packet_length == 8'd0) ? 8'(ZERO_LEN_SUB) : packet_length;
      cnt_d            = packet_count;
      exp_pkt_d        = '0;
      beat_idx_d       = 8'd1;
      pkt_err_d        = 1'b0;
      long_seen_d      = 1'b0;
      packets_rcvd_d   = '0;
      error_count_d    = '0;
      err_flags_d      = '0;
      first_err_pkt_d  = '0;
      first_err_beat_d = '0;
      first_err_vld_d  = 1'b0;
    end else begin
      if (start) pend_d = 1'b1;
      if (accept) begin
        err_flags_d = err_flags_q | {long_err, short_err, keep_err, data_err};
        if (any_err && !first_err_vld_q) begin
          first_err_vld_d  = 1'b1;
          first_err_pkt_d  = exp_pkt_q;
          first_err_beat_d = beat_idx_q;
        end
        if (AXIS_RX_TLAST) begin
          packets_rcvd_d = packets_rcvd_q + 64'd1;
          exp_pkt_d      = exp_pkt_q + 64'd1;
          beat_idx_d     = 8'd1;
          pkt_err_d      = 1'b0;
          long_seen_d    = 1'b0;
          if ((pkt_err_q || any_err) && (error_count_q != '1))
            error_count_d = error_count_q + 32'd1;
        end else begin
          pkt_err_d   = pkt_err_q || any_err;
          long_seen_d = long_seen_q || long_err;
          // Overlong packets park at 255 rather than wrapping back into range.
          if (beat_idx_q != 8'hFF) beat_idx_d = beat_idx_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      pend_q           <= 1'b0;
      len_q            <= '0;
      cnt_q            <= '0;
      exp_pkt_q        <= '0;
      beat_idx_q       <= '0;
      pkt_err_q        <= 1'b0;
      long_seen_q      <= 1'b0;
      packets_rcvd_q   <= '0;
      error_count_q    <= '0;
      err_flags_q      <= '0;
      first_err_pkt_q  <= '0;
      first_err_beat_q <= '0;
      first_err_vld_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_q           <= pend_d;
      len_q            <= len_d;
      cnt_q            <= cnt_d;
      exp_pkt_q        <= exp_pkt_d;
      beat_idx_q       <= beat_idx_d;
      pkt_err_q        <= pkt_err_d;
      long_seen_q      <= long_seen_d;
      packets_rcvd_q   <= packets_rcvd_d;
      error_count_q    <= error_count_d;
      err_flags_q      <= err_flags_d;
      first_err_pkt_q  <= first_err_pkt_d;
      first_err_beat_q <= first_err_beat_d;
      first_err_vld_q  <= first_err_vld_d;
    end
  end

  assign AXIS_RX_TREADY = tready;
  assign packets_rcvd   = packets_rcvd_q;
  assign error_count    = error_count_q;
  assign err_flags      = err_flags_q;
  assign first_err_pkt  = first_err_pkt_q;
  assign first_err_beat = first_err_beat_q;
  assign complete       = (state_q == RUN) && (packets_rcvd_q >= cnt_q);

endmodule
